// File: rtl/lab3_cla_serial_adder.sv
// Nibble-serial WIDTH-bit adder built around one 4-bit carry-lookahead stage.
// Operands are captured on an accepted start and summed LSB nibble first,
// one nibble per clock. The inter-nibble carry lives in a 1-bit register.
//
// Handshake: start is a request sampled on every rising edge. It is accepted
// in IDLE or DONE (so back-to-back operations are possible) and ignored while
// busy=1. An accepted operation ends with a single-cycle done pulse. At that
// point Sum/Cout/V are final, and they hold through IDLE until the next
// accepted start.
module lab3_cla_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             V,
  output logic [1:0]       state_dbg
);

  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             v_q, v_d;

  logic [3:0] a_nib, b_nib;
  logic [3:0] g, p, s;
  logic [4:0] c;

  // Select the operand nibble addressed by the current index.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int n = 0; n < N; n++) begin
      if (idx_q == IW'(n)) begin
        a_nib = a_q[4*n +: 4];
        b_nib = b_q[4*n +: 4];
      end
    end
  end

  // Two-level carry lookahead over one nibble, seeded from the carry register.
  // Every carry is a flat sum of products, so there is no ripple chain.
  always_comb begin
    g    = a_nib & b_nib;
    p    = a_nib ^ b_nib;
    c[0] = carry_q;
    c[1] = g[0] | (p[0] & carry_q);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & carry_q);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & carry_q);
    s    = p ^ c[3:0];
  end

  // Next-state and datapath updates; every register holds by default.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    v_d     = v_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          carry_d = Cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          v_d     = 1'b0;
          state_d = S_RUN;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        for (int n = 0; n < N; n++) begin
          if (idx_q == IW'(n)) begin
            sum_d[4*n +: 4] = s;
          end
        end
        carry_d = c[4];
        if (idx_q == IW'(N - 1)) begin
          // The top nibble's c3/c4 are the carries into and out of the MSB.
          cout_d  = c[4];
          v_d     = c[3] ^ c[4];
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      v_q     <= v_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign Sum       = sum_q;
  assign Cout      = cout_q;
  assign V         = v_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_lab3_cla_serial_adder.sv
// Testbench for lab3_cla_serial_adder (WIDTH=16).
// A timing/arithmetic model predicts busy, done and the results from the
// accept edge of each operation. Directed cases pin the model with literal
// values. Randomized traffic (with occasional resets) follows.
module tb_lab3_cla_serial_adder;

  localparam int W = 16;
  localparam int N = W / 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A, B;
  logic         Cin;
  logic         busy, done;
  logic [W-1:0] Sum;
  logic         Cout, V;
  logic [1:0]   state_dbg;

  int tests = 0;
  int fails = 0;

  lab3_cla_serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Cin(Cin),
    .busy(busy), .done(done), .Sum(Sum), .Cout(Cout), .V(V),
    .state_dbg(state_dbg)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: {V, Cout, Sum} computed with plain wide arithmetic.
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic c);
    logic [W:0]   full;
    logic [W-1:0] s;
    logic         v;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    s    = full[W-1:0];
    v    = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    return {v, full[W], s};
  endfunction

  // Scoreboard: expected results queued at accept, retired at done.
  logic [W+1:0] exp_q[$];
  logic [W+1:0] res = '0;
  int           edge_n = 0;
  int           acc_e = -1000;
  bit           act = 1'b0;
  bit           chk_en = 1'b0;

  // Model: track accept edge and retire results on rising edges.
  always @(posedge clk) begin
    bit in_run;
    edge_n++;
    if (rst) begin
      act = 1'b0;
      exp_q.delete();
      res = '0;
    end else begin
      if (act && edge_n == acc_e + N) begin
        if (exp_q.size() > 0) res = exp_q.pop_front();
      end
      in_run = act && (edge_n - 1 >= acc_e) && (edge_n - 1 <= acc_e + N - 1);
      if (!in_run && start) begin
        act   = 1'b1;
        acc_e = edge_n;
        exp_q.push_back(ref_add(A, B, Cin));
      end
    end
  end

  // Compare process: checks every cycle on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      bit exp_busy, exp_done;
      exp_busy = act && (edge_n >= acc_e) && (edge_n <= acc_e + N - 1);
      exp_done = act && (edge_n == acc_e + N);
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("done", 32'(done), 32'(exp_done));
      if (!exp_busy) begin
        chk("sum",  32'(Sum),  32'(res[W-1:0]));
        chk("cout", 32'(Cout), 32'(res[W]));
        chk("v",    32'(V),    32'(res[W+1]));
      end
    end
  end

  // Driver: one-cycle start, then watch 12 cycles for exactly one done.
  task automatic do_op(input string name, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic c,
                       input logic [W-1:0] es, input logic ec,
                       input logic ev);
    int nd, first;
    logic [W-1:0] cs;
    logic cc, cv;
    nd = 0; first = -1; cs = '0; cc = 1'b0; cv = 1'b0;
    @(negedge clk);
    start = 1'b1; A = a; B = b; Cin = c;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        nd++;
        if (first < 0) begin
          first = i; cs = Sum; cc = Cout; cv = V;
        end
      end
    end
    chk({name, "_ndone"}, 32'(nd), 32'd1);
    chk({name, "_lat"}, 32'(first), 32'd5);
    chk({name, "_sum"}, 32'(cs), 32'(es));
    chk({name, "_cout"}, 32'(cc), 32'(ec));
    chk({name, "_v"}, 32'(cv), 32'(ev));
  endtask

  initial begin
    int nd, first, prev;
    logic [W-1:0] cs;
    rst = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum",  32'(Sum),  32'd0);
    chk("rst_cout", 32'(Cout), 32'd0);
    chk("rst_v",    32'(V),    32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases with hand-computed results
    do_op("add_5555",  16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    do_op("carry_all", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    do_op("ovf_pos",   16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op("ovf_neg",   16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Start during RUN must be ignored
    nd = 0; first = -1; cs = '0;
    @(negedge clk);
    start = 1'b1; A = 16'h0001; B = 16'h0001; Cin = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        if (first < 0) begin first = i; cs = Sum; end
      end
      start = (i == 2);
      if (i == 2) begin A = 16'hAAAA; B = 16'h5555; end
    end
    chk("ign_ndone", 32'(nd), 32'd1);
    chk("ign_lat", 32'(first), 32'd5);
    chk("ign_sum", 32'(cs), 32'h0002);

    // Start held high with alternating pairs: done every N+1 cycles
    nd = 0; prev = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) begin
        if (prev >= 0) chk("b2b_period", 32'(i - prev), 32'(N + 1));
        prev = i;
        nd++;
      end
      start = 1'b1;
      if (i % 2 == 0) begin A = 16'h1111; B = 16'h2222; Cin = 1'b0; end
      else begin A = 16'h9999; B = 16'hF00F; Cin = 1'b1; end
    end
    start = 1'b0;
    chk("b2b_count", 32'(nd >= 5), 32'd1);
    repeat (6) @(negedge clk);

    // Reset two edges after start abandons the operation
    nd = 0;
    start = 1'b1; A = 16'h0F0F; B = 16'h0101; Cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum",  32'(Sum),  32'd0);
    chk("abort_cout", 32'(Cout), 32'd0);
    chk("abort_v",    32'(V),    32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_nodone", 32'(nd), 32'd0);
    do_op("after_rst", 16'h0F0F, 16'h0101, 1'b1, 16'h1011, 1'b0, 1'b0);

    // Randomized traffic checked by the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 5))
        0: A = 16'hFFFF;
        1: A = 16'h7FFF;
        2: A = 16'h8000;
        default: A = W'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0: B = 16'h0000;
        1: B = 16'h8000;
        2: B = 16'h0001;
        default: B = W'($urandom);
      endcase
      Cin = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 149) == 0);
    end
    start = 1'b0;
    rst = 1'b0;
    repeat (10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
